// File: rtl/card_shoe_if.sv
// Handshake bundle between the game-control FSM (master) and the card shoe (slave).
// The master raises deal/shuffle requests; the shoe returns the dealt card and the shoe status.
interface card_shoe_if;
    logic       deal_req;
    logic       shuffle_req;
    logic       ready;
    logic       card_valid;
    logic [3:0] card;
    logic [8:0] cards_left;
    logic       shoe_empty;

    modport master (
        output deal_req,
        output shuffle_req,
        input  ready,
        input  card_valid,
        input  card,
        input  cards_left,
        input  shoe_empty
    );

    modport slave (
        input  deal_req,
        input  shuffle_req,
        output ready,
        output card_valid,
        output card,
        output cards_left,
        output shoe_empty
    );
endinterface

// File: rtl/card_shoe.sv
// Shoe of DECKS decks holding per-rank remaining counts; deals the rank picked by a free-running
// 1..13 counter sampled at request time, skipping forward past exhausted ranks.
module card_shoe #(
    parameter int DECKS = 1
) (
    input  logic        clock,
    input  logic        resetb,
    card_shoe_if.slave  bus
);

    localparam logic [5:0] PER_RANK = 6'(4 * DECKS);
    localparam logic [8:0] FULL     = 9'(52 * DECKS);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        IDLE   = 2'd1,
        SEARCH = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic       armed;
    logic [3:0] rank_ctr;
    logic [3:0] idx, idx_nx;
    logic [3:0] ptr, ptr_nx;
    logic [5:0] counts [1:13];
    logic       cnt_we;
    logic [3:0] cnt_addr;
    logic [5:0] cnt_data;
    logic [8:0] cards_left, left_nx;
    logic [3:0] card, card_nx;
    logic       card_valid, valid_nx;

    function automatic logic [3:0] next_rank(input logic [3:0] r);
        return (r == 4'd13) ? 4'd1 : r + 4'd1;
    endfunction

    // Reset is released synchronously: the first edge after resetb rises only arms the FSM.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) armed <= 1'b0;
        else         armed <= 1'b1;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) rank_ctr <= 4'd1;
        else         rank_ctr <= next_rank(rank_ctr);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= FILL;
            idx        <= 4'd1;
            ptr        <= 4'd1;
            cards_left <= '0;
            card       <= '0;
            card_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            ptr        <= ptr_nx;
            cards_left <= left_nx;
            card       <= card_nx;
            card_valid <= valid_nx;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 1; i <= 13; i++) counts[i] <= '0;
        end else if (cnt_we) begin
            counts[cnt_addr] <= cnt_data;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        ptr_nx   = ptr;
        cnt_we   = 1'b0;
        cnt_addr = idx;
        cnt_data = PER_RANK;
        left_nx  = cards_left;
        card_nx  = card;
        valid_nx = 1'b0;
        if (armed) begin
            unique case (state)
                FILL: begin
                    cnt_we   = 1'b1;
                    cnt_addr = idx;
                    cnt_data = PER_RANK;
                    if (idx == 4'd13) begin
                        left_nx  = FULL;
                        state_nx = IDLE;
                    end else begin
                        idx_nx = idx + 4'd1;
                    end
                end
                IDLE: begin
                    if (bus.shuffle_req) begin
                        state_nx = FILL;
                        idx_nx   = 4'd1;
                    end else if (bus.deal_req && cards_left != 9'd0) begin
                        ptr_nx   = rank_ctr;
                        state_nx = SEARCH;
                    end
                end
                SEARCH: begin
                    // An exhausted rank passes the request on to the next rank up.
                    if (counts[ptr] != 6'd0) begin
                        cnt_we   = 1'b1;
                        cnt_addr = ptr;
                        cnt_data = counts[ptr] - 6'd1;
                        left_nx  = (cards_left != 9'd0) ? cards_left - 9'd1 : 9'd0;
                        card_nx  = ptr;
                        valid_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        ptr_nx = next_rank(ptr);
                    end
                end
                default: begin
                    state_nx = FILL;
                    idx_nx   = 4'd1;
                end
            endcase
        end
    end

    assign bus.ready      = (state == IDLE);
    assign bus.shoe_empty = (state == IDLE) && (cards_left == 9'd0);
    assign bus.card       = card;
    assign bus.card_valid = card_valid;
    assign bus.cards_left = cards_left;

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: a fixed vector table, directed corner sequences, and
// randomized requests compared against a transaction-level model of the shoe.
module tb_card_shoe;

    logic clock;
    logic resetb;

    card_shoe_if bus1 ();
    card_shoe_if bus8 ();

    card_shoe #(.DECKS(1)) dut  (.clock(clock), .resetb(resetb), .bus(bus1));
    card_shoe #(.DECKS(8)) dut8 (.clock(clock), .resetb(resetb), .bus(bus8));

    int vectors    = 0;
    int miscompares = 0;
    int edge_no    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edges counted since reset release; rank_ctr before edge n is ((n-1) mod 13)+1.
    always @(posedge clock or negedge resetb) begin
        if (!resetb) edge_no <= 0;
        else         edge_no <= edge_no + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic       deal;
        logic       shuffle;
        logic       ready;
        logic       valid;
        logic [3:0] card;
        logic [8:0] left;
    } vec_t;

    vec_t table_v [8];

    // Reference model state: what the shoe holds and when the current job completes.
    int   rem [1:13];
    int   m_left, m_card, m_rank, m_busy_end;
    bit   m_ready, m_valid, m_job_fill;
    int   m_decks;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive inputs at a falling edge, let one rising edge sample them, return at the next falling edge.
    task automatic applyStimulus(input logic d, input logic s);
        bus1.deal_req    = d;
        bus1.shuffle_req = s;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        bus1.deal_req    = 1'b0;
        bus1.shuffle_req = 1'b0;
        bus8.deal_req    = 1'b0;
        bus8.shuffle_req = 1'b0;
        @(negedge clock);
        resetb = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetb = 1'b1;
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 20 && !bus1.ready; c++) applyStimulus(1'b0, 1'b0);
        checkOutput("ready_after_fill", bus1.ready, 1);
    endtask

    task automatic model_init(input int decks);
        m_decks    = decks;
        for (int r = 1; r <= 13; r++) rem[r] = 0;
        m_left     = 0;
        m_card     = 0;
        m_ready    = 0;
        m_valid    = 0;
        m_job_fill = 1;
        m_busy_end = 14;
        m_rank     = 0;
    endtask

    task automatic model_step(input int e, input bit d, input bit s);
        int r, k;
        m_valid = 0;
        if (!m_ready) begin
            if (e == m_busy_end) begin
                if (m_job_fill) begin
                    for (int i = 1; i <= 13; i++) rem[i] = 4 * m_decks;
                    m_left = 52 * m_decks;
                end else begin
                    rem[m_rank]--;
                    m_left--;
                    m_card  = m_rank;
                    m_valid = 1;
                end
                m_ready = 1;
            end
        end else if (s) begin
            m_ready    = 0;
            m_job_fill = 1;
            m_busy_end = e + 13;
        end else if (d && m_left > 0) begin
            r = ((e - 1) % 13) + 1;
            k = 0;
            while (rem[r] == 0) begin
                r = (r % 13) + 1;
                k++;
            end
            m_rank     = r;
            m_job_fill = 0;
            m_ready    = 0;
            m_busy_end = e + 1 + k;
        end
    endtask

    task automatic deal_at_rank(input int r, output int lat, output int got);
        for (int c = 0; c < 13 && ((edge_no % 13) + 1) != r; c++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        lat = 0;
        got = -1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b0);
            lat++;
            if (bus1.card_valid) begin
                got = bus1.card;
                break;
            end
        end
    endtask

    initial begin
        int tally [1:13];
        int pulses, last_card, extra, lat, got, lows;
        bit d, s;

        // edge 14 ends the fill; ranks before edges 15.. are 2,3,4,...
        table_v[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 9'd52};
        table_v[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 9'd51};
        table_v[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 9'd51};
        table_v[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 9'd50};
        table_v[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 9'd50};
        table_v[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 9'd49};
        table_v[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 9'd49};
        table_v[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 9'd49};

        resetb           = 1'b0;
        bus1.deal_req    = 1'b0;
        bus1.shuffle_req = 1'b0;
        bus8.deal_req    = 1'b0;
        bus8.shuffle_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset_card", bus1.card, 0);
        checkOutput("reset_valid", bus1.card_valid, 0);
        checkOutput("reset_ready", bus1.ready, 0);
        checkOutput("reset_left", bus1.cards_left, 0);
        checkOutput("reset_empty", bus1.shoe_empty, 0);
        resetb = 1'b1;
        checkOutput("rank_ctr_start", dut.rank_ctr, 1);

        // Requests held through the whole fill must be ignored.
        for (int i = 1; i <= 14; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("fill_ready_e%0d", i), bus1.ready, (i == 14) ? 1 : 0);
            if (i <= 13) checkOutput($sformatf("rank_ctr_e%0d", i), dut.rank_ctr, (i % 13) + 1);
        end
        checkOutput("fill_left", bus1.cards_left, 52);
        checkOutput("fill_card", bus1.card, 0);

        foreach (table_v[i]) begin
            applyStimulus(table_v[i].deal, table_v[i].shuffle);
            checkOutput($sformatf("vec%0d_ready", i), bus1.ready, table_v[i].ready);
            checkOutput($sformatf("vec%0d_valid", i), bus1.card_valid, table_v[i].valid);
            checkOutput($sformatf("vec%0d_card", i), bus1.card, table_v[i].card);
            checkOutput($sformatf("vec%0d_left", i), bus1.cards_left, table_v[i].left);
        end
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("refill_ready", bus1.ready, (i == 12) ? 1 : 0);
        end
        checkOutput("refill_left", bus1.cards_left, 52);
        checkOutput("refill_card", bus1.card, 6);

        // Hold deal_req until the 52-card shoe runs dry.
        do_reset();
        wait_ready();
        for (int r = 1; r <= 13; r++) tally[r] = 0;
        pulses    = 0;
        last_card = 0;
        for (int c = 0; c < 600 && !bus1.shoe_empty; c++) begin
            applyStimulus(1'b1, 1'b0);
            if (bus1.card_valid) begin
                pulses++;
                last_card = bus1.card;
                checkOutput("deal_card_range", (bus1.card >= 1 && bus1.card <= 13) ? 1 : 0, 1);
                if (bus1.card >= 1 && bus1.card <= 13) tally[bus1.card]++;
            end
        end
        checkOutput("drain_pulses", pulses, 52);
        for (int r = 1; r <= 13; r++) checkOutput($sformatf("drain_rank%0d", r), tally[r], 4);
        checkOutput("drain_left", bus1.cards_left, 0);
        checkOutput("drain_empty", bus1.shoe_empty, 1);
        extra = 0;
        for (int c = 0; c < 26; c++) begin
            applyStimulus(1'b1, 1'b0);
            if (bus1.card_valid) extra++;
        end
        checkOutput("empty_no_pulse", extra, 0);
        checkOutput("empty_card_hold", bus1.card, last_card);
        checkOutput("empty_still", bus1.shoe_empty, 1);

        // Exhaust rank 7, then a request landing on 7 must skip to 8 one cycle later.
        do_reset();
        wait_ready();
        for (int n = 0; n < 4; n++) begin
            deal_at_rank(7, lat, got);
            checkOutput("rank7_card", got, 7);
            checkOutput("rank7_latency", lat, 1);
        end
        deal_at_rank(7, lat, got);
        checkOutput("skip_card", got, 8);
        checkOutput("skip_latency", lat, 2);
        checkOutput("rank7_count", dut.counts[7], 0);

        // Shuffle and deal together after 20 deals: shuffle wins, card survives.
        do_reset();
        wait_ready();
        pulses = 0;
        for (int c = 0; c < 200 && pulses < 20; c++) begin
            applyStimulus(1'b1, 1'b0);
            if (bus1.card_valid) begin
                pulses++;
                last_card = bus1.card;
            end
        end
        checkOutput("pre_shuffle_deals", pulses, 20);
        checkOutput("pre_shuffle_left", bus1.cards_left, 32);
        applyStimulus(1'b1, 1'b1);
        extra = bus1.card_valid;
        lows  = bus1.ready ? 0 : 1;
        for (int c = 0; c < 13; c++) begin
            applyStimulus(1'b0, 1'b0);
            if (bus1.card_valid) extra++;
            if (!bus1.ready) lows++;
        end
        checkOutput("shuffle_no_pulse", extra, 0);
        checkOutput("shuffle_ready_low", lows, 13);
        checkOutput("shuffle_ready_back", bus1.ready, 1);
        checkOutput("shuffle_left", bus1.cards_left, 52);
        checkOutput("shuffle_card_hold", bus1.card, last_card);

        // Eight-deck shoe drained by a held request.
        do_reset();
        for (int c = 0; c < 20 && !bus8.ready; c++) begin
            @(posedge clock);
            @(negedge clock);
        end
        checkOutput("d8_ready", bus8.ready, 1);
        checkOutput("d8_left", bus8.cards_left, 416);
        for (int r = 1; r <= 13; r++) tally[r] = 0;
        pulses = 0;
        bus8.deal_req = 1'b1;
        for (int c = 0; c < 4000 && !bus8.shoe_empty; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (bus8.card_valid) begin
                pulses++;
                if (bus8.card >= 1 && bus8.card <= 13) tally[bus8.card]++;
            end
        end
        bus8.deal_req = 1'b0;
        checkOutput("d8_pulses", pulses, 416);
        for (int r = 1; r <= 13; r++) checkOutput($sformatf("d8_rank%0d", r), tally[r], 32);
        checkOutput("d8_empty", bus8.shoe_empty, 1);

        // Asynchronous reset landing while a search is in flight.
        do_reset();
        wait_ready();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pre_abort_valid", bus1.card_valid, 1);
        applyStimulus(1'b1, 1'b0);
        bus1.deal_req = 1'b0;
        resetb = 1'b0;
        #1;
        checkOutput("abort_card", bus1.card, 0);
        checkOutput("abort_left", bus1.cards_left, 0);
        checkOutput("abort_valid", bus1.card_valid, 0);
        checkOutput("abort_ready", bus1.ready, 0);
        @(negedge clock);
        resetb = 1'b1;
        for (int c = 0; c < 14; c++) applyStimulus(1'b0, 1'b0);
        checkOutput("abort_refill_ready", bus1.ready, 1);
        checkOutput("abort_refill_left", bus1.cards_left, 52);
        checkOutput("abort_refill_card", bus1.card, 0);

        // Randomized requests against the transaction-level model.
        do_reset();
        model_init(1);
        for (int c = 0; c < 1500; c++) begin
            d = 1'($urandom % 2);
            s = ($urandom % 40) == 0;
            applyStimulus(d, s);
            model_step(edge_no, d, s);
            checkOutput("rnd_ready", bus1.ready, m_ready);
            checkOutput("rnd_valid", bus1.card_valid, m_valid);
            checkOutput("rnd_card", bus1.card, m_card);
            checkOutput("rnd_left", bus1.cards_left, m_left);
            checkOutput("rnd_empty", bus1.shoe_empty, (m_ready && m_left == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Card source for the baccarat datapath; produces the 4-bit card codes that the 7-segment card display consumes.
- Models a shoe of DECKS standard decks: per-rank remaining counts, so no rank is dealt more than 4*DECKS times between shuffles.
- Rank selection uses a free-running 1..13 counter sampled at the moment of the request; the player's timing supplies the randomness.
- Deal requests come from the game-control FSM; the card output drives the card registers and the HEX displays.

Parameters:
- DECKS, 1, number of 52-card decks in the shoe; legal range 1..8.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- resetb  input  1  asynchronous, active-low reset.
- deal_req  input  1  request one card; sampled only when ready=1.
- shuffle_req  input  1  refill the shoe; sampled only when ready=1.
- ready  output  1  high in IDLE; low during FILL and SEARCH.
- card_valid  output  1  one-cycle pulse when card is updated.
- card  output  4  last dealt card, 1=A .. 13=K; 0 = none dealt (blank code).
- cards_left  output  9  cards remaining in the shoe.
- shoe_empty  output  1  high when cards_left==0 and state is IDLE.

Behaviour:
- Reset (async, resetb=0):
  - card=0, card_valid=0, cards_left=0, ready=0, shoe_empty=0.
  - rank_ctr=1, all 13 rank counts=0, state=FILL, fill index=1.
- rank_ctr:
  - Increments every clock in every state, wrapping 13->1.
  - Never takes the values 0, 14 or 15.
- FILL:
  - One rank per cycle: count[idx] <= 4*DECKS for idx 1..13 (13 cycles).
  - On the idx=13 cycle: cards_left <= 52*DECKS, state <= IDLE.
  - ready=1 on the 14th edge after reset release.
  - deal_req and shuffle_req are ignored during FILL.
- IDLE:
  - shuffle_req=1: state <= FILL, idx <= 1. Has priority over a simultaneous deal_req. card is retained.
  - Else deal_req=1 and cards_left!=0: ptr <= rank_ctr, state <= SEARCH.
  - deal_req with cards_left==0: ignored; card_valid stays 0; shoe_empty stays 1.
- SEARCH:
  - count[ptr]!=0: count[ptr]--, cards_left--, card <= ptr, card_valid <= 1 for exactly one cycle, state <= IDLE.
  - count[ptr]==0: ptr <= ptr+1 (wrapping 13->1); stay in SEARCH.
  - A non-empty shoe guarantees a hit within 13 cycles.
- Latency: deal_req accepted at edge N -> card_valid high after edge N+1+k, where k (0..12) is the number of exhausted ranks skipped.
- Back-to-back deals: ready is 1 in the same cycle card_valid is 1, so a held deal_req is accepted on that edge.
- Requests: level-sampled, no queuing. A request asserted while ready=0 is dropped unless still held when ready=1.
- Widths:
  - Rank counts: 6 bits.
  - cards_left: 9 bits; never wraps below 0.
  - card only ever takes the values 0..13.
- Reset mid-FILL or mid-SEARCH: immediate return to the reset values; no partial decrement is retained.

Test Plan:
- Reset, DECKS=1 -> card=0, card_valid=0, ready=0 for 13 edges, ready=1 with cards_left=52 after edge 14; rank_ctr sequence 1..13,1 checked.
- Hold deal_req=1 for 52 deals, DECKS=1 -> exactly 52 card_valid pulses, each rank 1..13 exactly 4 times, card never 0/14/15, cards_left reaches 0, shoe_empty=1; further deal_req produces no pulse and card holds its last value.
- Exhaust rank 7 (4 deals timed to rank_ctr=7), then request with rank_ctr=7 -> card=8, card_valid one cycle later than the un-exhausted case (k=1); count[7] stays 0.
- After 20 deals, assert deal_req and shuffle_req together in IDLE -> no card_valid, ready low 13 cycles, cards_left=52, card keeps its previous value.
- DECKS=8 -> cards_left=416 after fill; 416 deals give each rank exactly 32 times, then shoe_empty=1.
- Drop resetb during SEARCH -> card=0, cards_left=0, card_valid=0 immediately (asynchronous); after release, the refill restores cards_left=52.
